pio_output_pulser: RTL and testbench
====================================

Name: pio_output_pulser

Overview:
- Avalon-MM slave output PIO: the CPU writes registers, and the block drives an 8-bit `out_port` (LEDs / game control lines).
- It is the write-side counterpart of the input-port PIOs on the CPU bus.
- Adds atomic set/clear registers and a hardware one-shot pulse generator, so software can produce timed strobes without busy-waiting.
- Sits behind the Avalon interconnect on the system clock.

Parameters:
- WIDTH, 8, width of `out_port` and of the data/mask registers.
- CNT_WIDTH, 16, width of the pulse-length register and down-counter.
- RESET_VALUE, 0, reset value of the data register.
- DEFAULT_PULSE, 1000, reset value of the pulse-length register (cycles).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  register select (word offset).
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  driven output lines.

Behaviour:
- Register map (address: write / read):
  - 0: data <= writedata[WIDTH-1:0] / returns data.
  - 1: pulse trigger: pmask <= writedata[WIDTH-1:0], count <= plen / returns pmask.
  - 2: plen <= writedata[CNT_WIDTH-1:0] / returns plen.
  - 3: any write aborts the pulse (count <= 0) / returns {count, 15'b0, active}, with count in bits [CNT_WIDTH+15:16].
  - 4: data <= data | writedata[WIDTH-1:0] (outset) / returns 0.
  - 5: data <= data & ~writedata[WIDTH-1:0] (outclear) / returns 0.
  - 6, 7: writes ignored / return 0.
- Reset (asynchronous):
  - data=RESET_VALUE, pmask=0, plen=DEFAULT_PULSE, count=0, readdata=0.
  - out_port=RESET_VALUE.
- active = (count != 0).
- out_port = data | (pmask & {WIDTH{active}}). It is a combinational OR of registers only; no input-to-output path.
- Counter:
  - When active and there is no write to address 1 or 3 in that cycle, count <= count-1.
  - A pulse therefore holds `out_port` bits high for exactly plen cycles, starting the cycle after the trigger write is sampled.
- Pulse-length boundary: plen=0 at trigger loads count=0, so no pulse and pmask updates silently.
- Retrigger while active: count reloads to plen and pmask is replaced. Old mask bits drop the next cycle unless they are also in the new mask.
- Trigger write in the same cycle the count would reach 0: the reload wins and the pulse continues.
- Write to address 2 while active: affects only the next trigger; the running count is unchanged.
- Bits set in data stay high regardless of pulse expiry; the pulse only ORs bits in.
- Read timing:
  - readdata <= mux(address) every cycle, independent of chipselect (1-cycle read latency, no wait states).
  - Unused upper bits read 0.
  - A read of address 3 returns the count value before that cycle's decrement.
- Writes have zero wait states and take effect on the clock edge they are sampled.
- Reset asserted mid-pulse: count clears immediately (asynchronously) and `out_port` returns to RESET_VALUE with no residual pulse.
- No CPU interrupt; software polls address 3 bit 0.

Test Plan:
- Reset, then read addresses 0, 2, 3 → readdata = 0x00, 1000 (0x3E8), 0x00000000; out_port=0x00.
- Write 0xA5 to address 0, then 0x0F to address 4, then 0x81 to address 5 → out_port goes 0xA5, 0xAF, 0x2E on successive cycles; read address 0 returns 0x2E.
- Write plen=3 (address 2), then trigger mask 0x10 (address 1) with data=0x01 → out_port=0x11 for exactly 3 cycles, then 0x01; address 3 reads 0x00030001, 0x00020001, 0x00010001, 0x00000000.
- Retrigger with mask 0x20 when count=1 → count reloads to 3; out_port=0x21 for 3 more cycles and bit 4 drops the same cycle.
- During a pulse with plen=100: write address 3 → out_port returns to data next cycle. Separately, assert reset_n=0 mid-pulse → out_port=RESET_VALUE asynchronously and count reads 0 after release.
- Trigger with plen=0 → no pulse, active stays 0; address 1 reads back the new mask; a write to address 6 leaves all state unchanged.

Source files
------------

// File: rtl/pio_output_pulser_if.sv
// Avalon-MM register bus between the CPU interconnect and the output PIO.
// Latency: n/a (signal bundle only); readdata is registered inside the slave.
// Backpressure: none; the slave never inserts wait states.
interface pio_output_pulser_if;
    logic [2:0]  address;     // word offset
    logic        chipselect;  // slave select
    logic        write_n;     // active-low write strobe
    logic [31:0] writedata;
    logic [31:0] readdata;    // valid one cycle after address is presented

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_output_pulser.sv
// Output PIO with atomic set/clear and a hardware one-shot pulse generator.
// Latency: writes take effect on the sampling edge; readdata is 1 cycle after address.
// Backpressure: none; zero wait states, every access completes in one cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port - data | (pulse mask while the pulse counter is non-zero)
//
// Register map (word offsets):
//   0 data        1 pulse trigger / mask   2 pulse length   3 status / abort
//   4 set bits    5 clear bits             6,7 reserved (read 0)
module pio_output_pulser #(
    parameter int               WIDTH         = 8,
    parameter int               CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               DEFAULT_PULSE = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_output_pulser_if.slave   bus,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0]     data;
    logic [WIDTH-1:0]     pmask;
    logic [CNT_WIDTH-1:0] plen;
    logic [CNT_WIDTH-1:0] count;
    logic                 active;
    logic                 wr;
    logic [WIDTH-1:0]     wr_bits;
    logic [31:0]          rd_mux;
    logic                 unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_bits   = bus.writedata[WIDTH-1:0];
    assign active    = (count != '0);
    assign unused_wd = ^bus.writedata;

    // Pure OR of registers: no combinational path from the bus to the pins.
    assign out_port = data | (pmask & {WIDTH{active}});

    // Read mux sees pre-edge register values, so a status read returns the
    // count before this cycle's decrement.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0: rd_mux[WIDTH-1:0] = data;
            3'd1: rd_mux[WIDTH-1:0] = pmask;
            3'd2: rd_mux[CNT_WIDTH-1:0] = plen;
            3'd3: begin
                rd_mux[CNT_WIDTH+15:16] = count;
                rd_mux[0]               = active;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data         <= RESET_VALUE;
            pmask        <= '0;
            plen         <= CNT_WIDTH'(DEFAULT_PULSE);
            count        <= '0;
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;

            if (wr) begin
                case (bus.address)
                    3'd0: data  <= wr_bits;
                    3'd1: pmask <= wr_bits;
                    3'd2: plen  <= bus.writedata[CNT_WIDTH-1:0];
                    3'd4: data  <= data | wr_bits;
                    3'd5: data  <= data & ~wr_bits;
                    default: ;
                endcase
            end

            // Trigger reload beats both abort and decrement, so a retrigger on
            // the final pulse cycle extends the pulse without a gap.
            if (wr && bus.address == 3'd1) begin
                count <= plen;
            end else if (wr && bus.address == 3'd3) begin
                count <= '0;
            end else if (active) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pio_output_pulser.sv
module tb_pio_output_pulser;

    localparam int         WIDTH  = 8;
    localparam logic [7:0] RV     = 8'h00;
    localparam int         DEF_PL = 1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;

    pio_output_pulser_if bus ();

    pio_output_pulser #(
        .WIDTH(WIDTH), .CNT_WIDTH(16), .RESET_VALUE(RV), .DEFAULT_PULSE(DEF_PL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the pulse is tracked as an absolute end time rather than
    // a down-counter. t counts clock edges; the pulse is live while t < m_end.
    int         t      = 0;
    int         m_end  = 0;
    logic [7:0] m_data = RV;
    logic [7:0] m_mask = '0;
    int         m_plen = DEF_PL;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int remaining();
        return (m_end > t) ? (m_end - t) : 0;
    endfunction

    function automatic logic [7:0] exp_out();
        return m_data | ((m_end > t) ? m_mask : 8'h00);
    endfunction

    // One bus cycle: drive at negedge, predict, let the edge happen, check #1 later.
    task automatic cyc(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        int          cnt;
        @(negedge clk);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;

        cnt = remaining();
        case (a)
            3'd0:    exp_rd = {24'h0, m_data};
            3'd1:    exp_rd = {24'h0, m_mask};
            3'd2:    exp_rd = 32'(m_plen);
            3'd3:    exp_rd = (32'(cnt) << 16) | ((cnt != 0) ? 32'd1 : 32'd0);
            default: exp_rd = 32'h0;
        endcase

        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: begin m_mask = wd[7:0]; m_end = t + 1 + m_plen; end
                3'd2: m_plen = int'(wd[15:0]);
                3'd3: m_end = t + 1;
                3'd4: m_data = m_data | wd[7:0];
                3'd5: m_data = m_data & ~wd[7:0];
                default: ;
            endcase
        end

        @(posedge clk);
        t++;
        #1;
        check($sformatf("readdata[a%0d]", a), bus.readdata, exp_rd);
        check("out_port", {24'h0, out_port}, {24'h0, exp_out()});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic model_reset();
        m_data = RV;
        m_mask = '0;
        m_plen = DEF_PL;
        m_end  = 0;
    endtask

    // Reset lands between edges to exercise the asynchronous path.
    task automatic mid_reset();
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_port", {24'h0, out_port}, {24'h0, RV});
        check("rst_readdata", bus.readdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("init_out_port", {24'h0, out_port}, {24'h0, RV});
        check("init_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values.
        rd(3'd0); rd(3'd2); rd(3'd3);
        check("reset_plen_const", bus.readdata, 32'h0);  // addr 3 just read
        rd(3'd2);
        check("reset_plen_1000", bus.readdata, 32'd1000);

        // Data / set / clear.
        wr(3'd0, 32'hA5); wr(3'd4, 32'h0F); wr(3'd5, 32'h81);
        check("setclr_out", {24'h0, out_port}, 32'h2E);
        rd(3'd0);

        // Short pulse, status read every cycle while it runs.
        wr(3'd2, 32'd3); wr(3'd0, 32'h01); wr(3'd1, 32'h10);
        rd(3'd3);
        check("pulse_status3", bus.readdata, 32'h0003_0001);
        rd(3'd3); rd(3'd3); rd(3'd3);
        check("pulse_done", bus.readdata, 32'h0);
        rd(3'd3);

        // Retrigger when count is 1.
        wr(3'd1, 32'h10); rd(3'd3); rd(3'd3);
        wr(3'd1, 32'h20);
        check("retrig_out", {24'h0, out_port}, 32'h21);
        repeat (4) rd(3'd3);

        // Retrigger on the cycle the count would hit zero.
        wr(3'd1, 32'h02); rd(3'd0); rd(3'd0); wr(3'd1, 32'h04);
        repeat (4) rd(3'd3);

        // Long pulse, plen change mid-pulse, abort.
        wr(3'd2, 32'd100); wr(3'd1, 32'h40); rd(3'd3);
        wr(3'd2, 32'd5); rd(3'd3); wr(3'd3, 32'hFFFF);
        check("abort_out", {24'h0, out_port}, 32'h01);
        rd(3'd3);

        // Long pulse cut by asynchronous reset.
        wr(3'd2, 32'd100); wr(3'd1, 32'hC0); rd(3'd3); rd(3'd3);
        mid_reset();
        rd(3'd3); rd(3'd2); rd(3'd0);

        // Zero-length trigger and reserved addresses.
        wr(3'd2, 32'd0); wr(3'd1, 32'h5A); rd(3'd3); rd(3'd1);
        wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd6);

        // Randomized traffic, short pulse lengths so pulses expire often.
        for (int i = 0; i < 2500; i++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 1) != 0);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = 32'($urandom_range(0, 8)) | (wd & 32'hFFFF_0000);
            cyc(cs, wn, a, wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
